// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the FIFO read scheduler.
package fifo_sched_pkg;

  localparam int unsigned MAX_ID_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  typedef struct packed {
    logic                    valid;
    logic [MAX_ID_WIDTH-1:0] id;
    logic                    last;
  } tag_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     winner_c,
  output logic [IDX_W-1:0] winner_idx_c,
  output logic             any_c
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    winner_c     = '0;
    winner_idx_c = '0;
    any_c        = 1'b0;
    sum          = '0;
    cand         = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(N)) begin
        sum = sum - (IDX_W+1)'(N);
      end
      cand = sum[IDX_W-1:0];
      if (!any_c && eligible[cand]) begin
        any_c          = 1'b1;
        winner_c[cand] = 1'b1;
        winner_idx_c   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_read_sched.sv
// Round-robin burst scheduler owning the read port of a single FIFO;
// tags returning read data with requester id and last-word flag.
module fifo_read_sched
  import fifo_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned ADDR_WIDTH = 13,
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned LATENCY    = 2,
  parameter  int unsigned LEN_WIDTH  = 8,
  localparam int unsigned ID_WIDTH   = id_width(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*LEN_WIDTH-1:0] req_len,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         fifo_ord,
  input  logic [ADDR_WIDTH:0]          fifo_full_count,
  input  logic [DATA_WIDTH-1:0]        fifo_odata,
  input  logic                         fifo_odata_valid,
  input  logic                         fifo_underflow,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  output logic [ID_WIDTH-1:0]          out_id,
  output logic                         out_last,
  output logic                         err
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned CMP_W = (LEN_WIDTH > CNT_W) ? LEN_WIDTH : CNT_W;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 ord_q, ord_d;
  logic                 err_q, err_d;
  tag_t                 pipe_q [LATENCY];
  tag_t                 pipe_d [LATENCY];
  tag_t                 tag_out;

  logic [LEN_WIDTH-1:0] len_arr [NUM_REQ];
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [ID_WIDTH-1:0]  win_idx;
  logic                 win_any;

  // A request is eligible only if the whole burst is already readable.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      len_arr[i]  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      eligible[i] = req[i] && (len_arr[i] != '0) &&
                    (CMP_W'(len_arr[i]) <= CMP_W'(fifo_full_count));
    end
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_WIDTH)
  ) u_arb (
    .eligible     (eligible),
    .ptr          (ptr_q),
    .winner_c     (win_onehot),
    .winner_idx_c (win_idx),
    .any_c        (win_any)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    grant_d = '0;
    ord_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = BURST;
          cnt_d   = len_arr[win_idx] - LEN_WIDTH'(1);
          ptr_d   = (win_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + ID_WIDTH'(1);
          id_d    = win_idx;
          grant_d = win_onehot;
          ord_d   = 1'b1;
        end
      end
      BURST: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - LEN_WIDTH'(1);
          ord_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tag pipeline tracks each read through the FIFO's fixed latency.
  always_comb begin
    pipe_d[0].valid = ord_q;
    pipe_d[0].id    = MAX_ID_WIDTH'(id_q);
    pipe_d[0].last  = ord_q && (cnt_q == '0);
    for (int unsigned i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  assign tag_out = pipe_q[LATENCY-1];
  assign err_d   = err_q || fifo_underflow || (fifo_odata_valid != tag_out.valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      grant_q <= '0;
      ord_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      grant_q <= grant_d;
      ord_q   <= ord_d;
      err_q   <= err_d;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  always_comb begin
    done = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      done[i] = tag_out.valid && tag_out.last && (tag_out.id == MAX_ID_WIDTH'(i));
    end
  end

  assign grant     = grant_q;
  assign fifo_ord  = ord_q;
  assign err       = err_q;
  assign out_data  = fifo_odata;
  assign out_valid = fifo_odata_valid;
  assign out_id    = tag_out.valid ? tag_out.id[ID_WIDTH-1:0] : '0;
  assign out_last  = tag_out.valid && tag_out.last;

endmodule
